// File: rtl/bcd2count.sv
// BCD time (hh:mm:ss.mmm) to binary millisecond count, one digit per NEclk falling edge.
// Optional digit range checking is compiled in with `define BCD2COUNT_RANGE_CHECK_EN.
module bcd2count #(
  parameter int BITS = 29
) (
  input  logic            NEclk,
  input  logic            Reset,
  input  logic            Start,
  input  logic [3:0]      bcd_h_1,
  input  logic [3:0]      bcd_h_0,
  input  logic [3:0]      bcd_min_1,
  input  logic [3:0]      bcd_min_0,
  input  logic [3:0]      bcd_s_1,
  input  logic [3:0]      bcd_s_0,
  input  logic [3:0]      bcd_ms_2,
  input  logic [3:0]      bcd_ms_1,
  input  logic [3:0]      bcd_ms_0,
  output logic            Busy,
  output logic            Done,
  output logic            Err,
  output logic [BITS-1:0] count
);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t          state;
  logic [35:0]     digits;
  logic [BITS-1:0] acc;
  logic [3:0]      step;
  logic [3:0]      cur_digit;
  logic [3:0]      cur_radix;
  logic [BITS-1:0] acc_next;
  logic            range_bad;

  // Digits are packed most-significant first: h_1 sits in [35:32], ms_0 in [3:0].
  always_comb begin
    cur_digit = 4'd0;
    cur_radix = 4'd10;
    case (step)
      4'd0: begin cur_digit = digits[35:32]; cur_radix = 4'd10; end
      4'd1: begin cur_digit = digits[31:28]; cur_radix = 4'd10; end
      4'd2: begin cur_digit = digits[27:24]; cur_radix = 4'd6;  end
      4'd3: begin cur_digit = digits[23:20]; cur_radix = 4'd10; end
      4'd4: begin cur_digit = digits[19:16]; cur_radix = 4'd6;  end
      4'd5: begin cur_digit = digits[15:12]; cur_radix = 4'd10; end
      4'd6: begin cur_digit = digits[11:8];  cur_radix = 4'd10; end
      4'd7: begin cur_digit = digits[7:4];   cur_radix = 4'd10; end
      4'd8: begin cur_digit = digits[3:0];   cur_radix = 4'd10; end
      default: begin cur_digit = 4'd0; cur_radix = 4'd10; end
    endcase
    acc_next = acc * BITS'(cur_radix) + BITS'(cur_digit);
  end

`ifdef BCD2COUNT_RANGE_CHECK_EN
  always_comb begin
    range_bad = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (digits[4*i +: 4] > 4'd9) range_bad = 1'b1;
    end
    if (digits[27:24] > 4'd5 || digits[19:16] > 4'd5) range_bad = 1'b1;
  end
`else
  assign range_bad = 1'b0;
`endif

  always_ff @(negedge NEclk) begin
    if (Reset) begin
      state  <= IDLE;
      Busy   <= 1'b0;
      Done   <= 1'b0;
      Err    <= 1'b0;
      count  <= '0;
      acc    <= '0;
      step   <= 4'd0;
      digits <= '0;
    end else begin
      case (state)
        IDLE: begin
          Done <= 1'b0;
          if (Start) begin
            digits <= {bcd_h_1, bcd_h_0, bcd_min_1, bcd_min_0,
                       bcd_s_1, bcd_s_0, bcd_ms_2, bcd_ms_1, bcd_ms_0};
            acc    <= '0;
            step   <= 4'd0;
            Err    <= 1'b0;
            Busy   <= 1'b1;
            state  <= CONV;
          end
        end
        CONV: begin
          acc <= acc_next;
          if (step == 4'd8) begin
            count <= range_bad ? '0 : acc_next;
            Err   <= range_bad;
            Busy  <= 1'b0;
            Done  <= 1'b1;
            state <= DONE;
          end else begin
            step <= step + 4'd1;
          end
        end
        DONE: begin
          Done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          Busy  <= 1'b0;
          Done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd2count.sv
// Self-checking bench for bcd2count: directed scenarios plus randomized conversions
// checked against an arithmetic hh:mm:ss.mmm -> milliseconds model.
module tb_bcd2count;
  localparam int BITS = 29;

  logic            NEclk = 1'b0;
  logic            Reset;
  logic            Start;
  logic [3:0]      dig [9];
  logic            Busy, Done, Err;
  logic [BITS-1:0] count;

  int vectors     = 0;
  int miscompares = 0;

  bcd2count #(.BITS(BITS)) dut (
    .NEclk(NEclk), .Reset(Reset), .Start(Start),
    .bcd_h_1(dig[0]), .bcd_h_0(dig[1]),
    .bcd_min_1(dig[2]), .bcd_min_0(dig[3]),
    .bcd_s_1(dig[4]), .bcd_s_0(dig[5]),
    .bcd_ms_2(dig[6]), .bcd_ms_1(dig[7]), .bcd_ms_0(dig[8]),
    .Busy(Busy), .Done(Done), .Err(Err), .count(count)
  );

  always #5 NEclk = ~NEclk;

  // Outputs are observed 1 time unit after each active (falling) edge.
  task automatic tick();
    @(negedge NEclk);
    #1;
  endtask

  function automatic logic [BITS-1:0] model_count(input logic [3:0] d [9]);
    longint hours, mins, secs, ms, total;
    hours = 10 * longint'(d[0]) + longint'(d[1]);
    mins  = 10 * longint'(d[2]) + longint'(d[3]);
    secs  = 10 * longint'(d[4]) + longint'(d[5]);
    ms    = 100 * longint'(d[6]) + 10 * longint'(d[7]) + longint'(d[8]);
    total = ((hours * 60 + mins) * 60 + secs) * 1000 + ms;
    return BITS'(total % (longint'(1) << BITS));
  endfunction

  function automatic logic model_err(input logic [3:0] d [9]);
    logic bad;
    bad = 1'b0;
`ifdef BCD2COUNT_RANGE_CHECK_EN
    foreach (d[i]) if (d[i] > 9) bad = 1'b1;
    if (d[2] > 5 || d[4] > 5) bad = 1'b1;
`endif
    return bad;
  endfunction

  task automatic set_time(input int h, input int m, input int s, input int ms);
    dig[0] = 4'(h / 10);    dig[1] = 4'(h % 10);
    dig[2] = 4'(m / 10);    dig[3] = 4'(m % 10);
    dig[4] = 4'(s / 10);    dig[5] = 4'(s % 10);
    dig[6] = 4'(ms / 100);  dig[7] = 4'((ms / 10) % 10);
    dig[8] = 4'(ms % 10);
  endtask

  task automatic start_conv();
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  // Bounded wait for the Done strobe; n is the number of edges it took.
  task automatic wait_done(output int n);
    n = 0;
    while (Done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; Start = 1'b0;
    set_time(0, 0, 0, 0);
    tick(); tick();
    vectors++;
    if ({Busy, Done, Err} !== 3'b000 || count !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset: Busy/Done/Err=%b count=%0d, required 000 and 0",
               {Busy, Done, Err}, count);
    end
    Reset = 1'b0;
    tick();
  endtask

  task automatic test_known();
    set_time(1, 23, 45, 678);
    start_conv();
    for (int i = 0; i < 9; i++) begin
      vectors++;
      if (Busy !== 1'b1 || Done !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL known_busy[%0d]: Busy=%b Done=%b, required 1 0", i, Busy, Done);
      end
      tick();
    end
    vectors++;
    if (Busy !== 1'b0 || Done !== 1'b1 || Err !== 1'b0 || count !== 29'd5025678) begin
      miscompares++;
      $display("[TB] FAIL known_done: Busy=%b Done=%b Err=%b count=%0d, required 0 1 0 5025678",
               Busy, Done, Err, count);
    end
    tick();
    vectors++;
    if (Done !== 1'b0 || count !== 29'd5025678) begin
      miscompares++;
      $display("[TB] FAIL known_after: Done=%b count=%0d, required 0 5025678", Done, count);
    end
  endtask

  task automatic test_max();
    int n;
    set_time(99, 59, 59, 999);
    start_conv();
    wait_done(n);
    vectors++;
    if (n !== 9 || Err !== 1'b0 || count !== 29'd359999999) begin
      miscompares++;
      $display("[TB] FAIL max: edges=%0d Err=%b count=%0d, required 9 0 359999999", n, Err, count);
    end
    tick();
  endtask

  task automatic test_range();
    int n;
    logic            exp_err;
    logic [BITS-1:0] exp_cnt;
`ifdef BCD2COUNT_RANGE_CHECK_EN
    exp_err = 1'b1; exp_cnt = '0;
`else
    exp_err = 1'b0; exp_cnt = 29'd3600000;
`endif
    set_time(0, 60, 0, 0);
    start_conv();
    wait_done(n);
    vectors++;
    if (n !== 9 || Err !== exp_err || count !== exp_cnt) begin
      miscompares++;
      $display("[TB] FAIL range: edges=%0d Err=%b count=%0d, required 9 %b %0d",
               n, Err, count, exp_err, exp_cnt);
    end
    tick();
    vectors++;
    if (Err !== exp_err) begin
      miscompares++;
      $display("[TB] FAIL range_hold: Err=%b, required %b", Err, exp_err);
    end
  endtask

  task automatic test_ignore();
    int n, extra;
    logic [BITS-1:0] exp_cnt;
    set_time(12, 34, 56, 789);
    exp_cnt = model_count(dig);
    start_conv();
    tick();
    set_time(98, 76, 54, 321);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    wait_done(n);
    vectors++;
    if (n !== 7 || count !== exp_cnt) begin
      miscompares++;
      $display("[TB] FAIL ignore: edges=%0d count=%0d, required 7 %0d", n, count, exp_cnt);
    end
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (Done === 1'b1 || Busy === 1'b1) extra++;
    end
    vectors++;
    if (extra !== 0) begin
      miscompares++;
      $display("[TB] FAIL ignore_extra: activity edges=%0d, required 0", extra);
    end
  endtask

  task automatic test_reset_abort();
    int n, strobes;
    set_time(1, 0, 0, 0);
    start_conv();
    for (int i = 0; i < 4; i++) tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    vectors++;
    if (Busy !== 1'b0 || Done !== 1'b0 || Err !== 1'b0 || count !== '0) begin
      miscompares++;
      $display("[TB] FAIL abort: Busy=%b Done=%b Err=%b count=%0d, required 0 0 0 0",
               Busy, Done, Err, count);
    end
    strobes = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (Done === 1'b1) strobes++;
    end
    vectors++;
    if (strobes !== 0) begin
      miscompares++;
      $display("[TB] FAIL abort_done: strobes=%0d, required 0", strobes);
    end
    set_time(0, 0, 1, 0);
    start_conv();
    wait_done(n);
    vectors++;
    if (n !== 9 || count !== 29'd1000) begin
      miscompares++;
      $display("[TB] FAIL abort_restart: edges=%0d count=%0d, required 9 1000", n, count);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int n, last, dones;
    set_time(0, 0, 0, 1);
    Start = 1'b1;
    last = -1;
    dones = 0;
    for (int t = 1; t <= 45; t++) begin
      tick();
      if (Done === 1'b1) begin
        dones++;
        vectors++;
        if (count !== 29'd1 || (last >= 0 && t - last != 11)) begin
          miscompares++;
          $display("[TB] FAIL b2b[%0d]: count=%0d gap=%0d, required 1 11", dones, count, t - last);
        end
        last = t;
      end
    end
    Start = 1'b0;
    vectors++;
    if (dones !== 4) begin
      miscompares++;
      $display("[TB] FAIL b2b_count: strobes=%0d, required 4", dones);
    end
    wait_done(n);
    tick();
  endtask

  task automatic test_random();
    int n;
    logic [BITS-1:0] exp_cnt;
    logic            exp_err;
    for (int k = 0; k < 25; k++) begin
      foreach (dig[i]) dig[i] = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 3) == 0) dig[$urandom_range(0, 8)] = 4'($urandom_range(0, 15));
      exp_err = model_err(dig);
      exp_cnt = exp_err ? '0 : model_count(dig);
      start_conv();
      foreach (dig[i]) dig[i] = 4'($urandom_range(0, 15));
      wait_done(n);
      vectors++;
      if (n !== 9 || Err !== exp_err || count !== exp_cnt) begin
        miscompares++;
        $display("[TB] FAIL random[%0d]: edges=%0d Err=%b count=%0d, required 9 %b %0d",
                 k, n, Err, count, exp_err, exp_cnt);
      end
      tick();
    end
  endtask

  initial begin
    Reset = 1'b1;
    Start = 1'b0;
    set_time(0, 0, 0, 0);
    test_reset();
    test_known();
    test_max();
    test_range();
    test_ignore();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
